// File: rtl/data_sync_pkg.sv
// Shared definitions for the clock-domain-crossing blocks: handshake FSM
// encoding and the default synchronizer depth.
package data_sync_pkg;

  typedef enum logic {
    IDLE     = 1'b0,
    ACK_HOLD = 1'b1
  } sync_state_t;

  localparam int DEFAULT_NUM_STAGES = 2;

endpackage : data_sync_pkg

// File: rtl/data_sync_sync_chain.sv
// Plain flop chain used to bring a level into a new clock domain; shared by
// the request path here and the acknowledge return path on the source side.
module sync_chain
  import data_sync_pkg::*;
#(
  parameter int NUM_STAGES = DEFAULT_NUM_STAGES,
  parameter int WIDTH      = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [NUM_STAGES-1:0][WIDTH-1:0] chain;

  // Stage 0 catches the asynchronous input; later stages give it time to settle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= '0;
    end else begin
      chain <= {chain[NUM_STAGES-2:0], d};
    end
  end

  assign q = chain[NUM_STAGES-1];

endmodule : sync_chain

// File: rtl/data_sync.sv
// Destination-side receiver for a multi-bit bus: synchronizes the request
// level, captures the bus on its rising edge and holds a level acknowledge.
module data_sync
  import data_sync_pkg::*;
#(
  parameter int NUM_STAGES = DEFAULT_NUM_STAGES,
  parameter int BUS_WIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BUS_WIDTH-1:0] unsync_bus,
  input  logic                 bus_enable,
  output logic [BUS_WIDTH-1:0] sync_bus,
  output logic                 enable_pulse,
  output logic                 enable_ack,
  output logic                 busy
);

  logic        en_s;
  logic        en_d;
  logic        rise;
  sync_state_t state;

  sync_chain #(
    .NUM_STAGES (NUM_STAGES),
    .WIDTH      (1)
  ) u_en_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus_enable),
    .q   (en_s)
  );

  // Clearing en_d on reset guarantees a request still high after reset is
  // seen as a fresh rising edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_d <= 1'b0;
    end else begin
      en_d <= en_s;
    end
  end

  assign rise = en_s & ~en_d;

  // The bus is only sampled on the capture edge; the source guarantees it is
  // stable by then because the request has crossed the full chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      sync_bus     <= '0;
      enable_pulse <= 1'b0;
      enable_ack   <= 1'b0;
      busy         <= 1'b0;
    end else begin
      enable_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (rise) begin
            sync_bus     <= unsync_bus;
            enable_pulse <= 1'b1;
            enable_ack   <= 1'b1;
            busy         <= 1'b1;
            state        <= ACK_HOLD;
          end
        end
        ACK_HOLD: begin
          // A request that dips without en_s ever going low is the same request.
          if (!en_s) begin
            enable_ack <= 1'b0;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          enable_ack <= 1'b0;
          busy       <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule : data_sync

// File: tb/tb_data_sync.sv
// Directed bench for data_sync: a history-based model of the handshake is
// compared every cycle, plus hand-computed checks at the key edges.
module tb_data_sync;

  localparam int NS = 2;
  localparam int BW = 8;

  logic          clk;
  logic          rst;
  logic [BW-1:0] unsync_bus;
  logic          bus_enable;
  logic [BW-1:0] sync_bus;
  logic          enable_pulse;
  logic          enable_ack;
  logic          busy;

  int checks = 0;
  int errors = 0;
  int pulse_cnt = 0;

  data_sync #(
    .NUM_STAGES (NS),
    .BUS_WIDTH  (BW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .unsync_bus   (unsync_bus),
    .bus_enable   (bus_enable),
    .sync_bus     (sync_bus),
    .enable_pulse (enable_pulse),
    .enable_ack   (enable_ack),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: be_hist[i] is bus_enable as sampled i+1 edges before the current one.
  // A capture happens at edge k when the request was sampled low at k-NS-1 and
  // high at k-NS while no request is outstanding; ack drops at edge k once the
  // request was sampled low at k-NS.
  logic [NS:0]   be_hist = '0;
  logic [BW-1:0] m_bus = '0;
  logic          m_pulse = 1'b0;
  logic          m_ack = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      be_hist = '0;
      m_bus   = '0;
      m_pulse = 1'b0;
      m_ack   = 1'b0;
    end else begin
      m_pulse = 1'b0;
      if (!m_ack && be_hist[NS-1] && !be_hist[NS]) begin
        m_bus   = unsync_bus;
        m_pulse = 1'b1;
        m_ack   = 1'b1;
      end else if (m_ack && !be_hist[NS-1]) begin
        m_ack = 1'b0;
      end
      be_hist = {be_hist[NS-1:0], bus_enable};
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (enable_pulse === 1'b1) pulse_cnt++;
      checkOutput("model sync_bus", 32'(sync_bus), 32'(m_bus));
      checkOutput("model enable_pulse", 32'(enable_pulse), 32'(m_pulse));
      checkOutput("model enable_ack", 32'(enable_ack), 32'(m_ack));
      checkOutput("model busy", 32'(busy), 32'(m_ack));
    end
  end

  task automatic applyStimulus(input logic en, input logic [BW-1:0] data);
    bus_enable = en;
    unsync_bus = data;
  endtask

  task automatic waitEdges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkAll(input string tag, input logic [BW-1:0] bus,
                          input logic pulse, input logic ack, input logic bsy);
    checkOutput({tag, " sync_bus"}, 32'(sync_bus), 32'(bus));
    checkOutput({tag, " enable_pulse"}, 32'(enable_pulse), 32'(pulse));
    checkOutput({tag, " enable_ack"}, 32'(enable_ack), 32'(ack));
    checkOutput({tag, " busy"}, 32'(busy), 32'(bsy));
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 8'h00);
    #2;
    checkAll("reset", 8'h00, 1'b0, 1'b0, 1'b0);
    waitEdges(2);
    rst = 1'b0;

    waitEdges(10);
    checkAll("idle", 8'h00, 1'b0, 1'b0, 1'b0);

    // First request: sampled high at E0, capture at E0+2.
    applyStimulus(1'b1, 8'hA5);
    waitEdges(1);
    checkAll("lat E0", 8'h00, 1'b0, 1'b0, 1'b0);
    waitEdges(1);
    checkAll("lat E1", 8'h00, 1'b0, 1'b0, 1'b0);
    waitEdges(1);
    checkAll("capture A5", 8'hA5, 1'b1, 1'b1, 1'b1);
    waitEdges(1);
    checkAll("pulse once", 8'hA5, 1'b0, 1'b1, 1'b1);

    applyStimulus(1'b1, 8'h3C);
    waitEdges(3);
    checkAll("bus ignored", 8'hA5, 1'b0, 1'b1, 1'b1);

    // Drop: ack still high two edges later, low on the third.
    applyStimulus(1'b0, 8'h3C);
    waitEdges(2);
    checkAll("ack held", 8'hA5, 1'b0, 1'b1, 1'b1);
    waitEdges(1);
    checkAll("ack fall", 8'hA5, 1'b0, 1'b0, 1'b0);
    waitEdges(2);

    applyStimulus(1'b1, 8'h3C);
    waitEdges(2);
    checkAll("pre 3C", 8'hA5, 1'b0, 1'b0, 1'b0);
    waitEdges(1);
    checkAll("capture 3C", 8'h3C, 1'b1, 1'b1, 1'b1);
    waitEdges(1);
    checkAll("3C pulse once", 8'h3C, 1'b0, 1'b1, 1'b1);

    // Glitch between edges while acknowledged: never sampled, same request.
    waitEdges(2);
    applyStimulus(1'b0, 8'h77);
    #3;
    applyStimulus(1'b1, 8'h77);
    waitEdges(6);
    checkAll("glitch", 8'h3C, 1'b0, 1'b1, 1'b1);
    checkOutput("pulse count glitch", 32'(pulse_cnt), 32'd2);

    // Asynchronous reset mid-cycle with the request still held.
    applyStimulus(1'b1, 8'h5A);
    #2;
    rst = 1'b1;
    #1;
    checkAll("async rst", 8'h00, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #3;
    rst = 1'b0;
    waitEdges(2);
    checkAll("post rst E1", 8'h00, 1'b0, 1'b0, 1'b0);
    waitEdges(1);
    checkAll("recapture 5A", 8'h5A, 1'b1, 1'b1, 1'b1);
    waitEdges(1);
    checkAll("5A pulse once", 8'h5A, 1'b0, 1'b1, 1'b1);

    applyStimulus(1'b0, 8'h00);
    waitEdges(5);
    checkAll("final idle", 8'h5A, 1'b0, 1'b0, 1'b0);
    checkOutput("pulse count total", 32'(pulse_cnt), 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_data_sync
